object_bbox_tracker: RTL

Colour-window object tracker on the 640x480 pixel stream leaving the image-processing stage, placed alongside the VGA controller on the 25 MHz pixel clock. Each valid pixel is tested against a programmable RGB window. Per frame, the block accumulates the bounding box, match count and coordinate sums. At frame end it computes the centroid with a serial divider and publishes the results. It also re-emits the pixel stream with the previous frame's bounding box drawn on it.

---
 rtl/object_bbox_tracker.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/object_bbox_tracker.sv
// rtl/object_bbox_tracker.sv - colour-window object tracker: bbox, count, centroid per frame, box overlay
module object_bbox_tracker #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int MIN_COUNT = 64,
  parameter int DIV_W     = 28
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFRAME_START,
  input  logic        iDVAL,
  input  logic [9:0]  iR,
  input  logic [9:0]  iG,
  input  logic [9:0]  iB,
  input  logic [9:0]  iR_MIN,
  input  logic [9:0]  iR_MAX,
  input  logic [9:0]  iG_MIN,
  input  logic [9:0]  iG_MAX,
  input  logic [9:0]  iB_MIN,
  input  logic [9:0]  iB_MAX,
  input  logic        iOVERLAY,
  output logic [9:0]  oR,
  output logic [9:0]  oG,
  output logic [9:0]  oB,
  output logic        oDVAL,
  output logic [9:0]  oX_MIN,
  output logic [9:0]  oX_MAX,
  output logic [9:0]  oY_MIN,
  output logic [9:0]  oY_MAX,
  output logic [9:0]  oX_CEN,
  output logic [9:0]  oY_CEN,
  output logic [18:0] oCOUNT,
  output logic        oFOUND,
  output logic        oRESULT_VAL
);
  localparam int CW = 19;
  localparam int NW = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

  logic [9:0] x_q, y_q, px, py;
  logic       s1_dval_q, s1_match_q;
  logic [9:0] s1_x_q, s1_y_q;
  logic [9:0] pix_r_q, pix_g_q, pix_b_q;
  logic       pix_match, draw, frame_end;

  // A start coincident with a pixel places that pixel at (0,0).
  assign px = iFRAME_START ? 10'd0 : x_q;
  assign py = iFRAME_START ? 10'd0 : y_q;

  assign pix_match = (iR >= iR_MIN) && (iR <= iR_MAX) &&
                     (iG >= iG_MIN) && (iG <= iG_MAX) &&
                     (iB >= iB_MIN) && (iB <= iB_MAX);

  assign draw = iOVERLAY && oFOUND &&
                ((((px == oX_MIN) || (px == oX_MAX)) && (py >= oY_MIN) && (py <= oY_MAX)) ||
                 (((py == oY_MIN) || (py == oY_MAX)) && (px >= oX_MIN) && (px <= oX_MAX)));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_q        <= '0;
      y_q        <= '0;
      s1_dval_q  <= 1'b0;
      s1_match_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      pix_r_q    <= '0;
      pix_g_q    <= '0;
      pix_b_q    <= '0;
    end else begin
      if (iDVAL) begin
        if (px == 10'(H_ACT - 1)) begin
          x_q <= '0;
          y_q <= py + 10'd1;
        end else begin
          x_q <= px + 10'd1;
          y_q <= py;
        end
      end else if (iFRAME_START) begin
        x_q <= '0;
        y_q <= '0;
      end
      s1_dval_q  <= iDVAL;
      s1_match_q <= iDVAL && pix_match;
      s1_x_q     <= px;
      s1_y_q     <= py;
      pix_r_q    <= draw ? 10'd0    : iR;
      pix_g_q    <= draw ? 10'd1023 : iG;
      pix_b_q    <= draw ? 10'd0    : iB;
    end
  end

  assign frame_end = s1_dval_q && (s1_x_q == 10'(H_ACT - 1)) && (s1_y_q == 10'(V_ACT - 1));

  logic [9:0]       min_x_q, max_x_q, min_y_q, max_y_q, min_x_d, max_x_d, min_y_d, max_y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] sx_q, sy_q, sx_d, sy_d;
  logic [9:0]       snap_min_x_q, snap_max_x_q, snap_min_y_q, snap_max_y_q;
  logic [CW-1:0]    snap_cnt_q;
  logic [DIV_W-1:0] snap_sx_q, snap_sy_q;

  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    if (s1_match_q) begin
      if (s1_x_q < min_x_q) min_x_d = s1_x_q;
      if (s1_x_q > max_x_q) max_x_d = s1_x_q;
      if (s1_y_q < min_y_q) min_y_d = s1_y_q;
      if (s1_y_q > max_y_q) max_y_d = s1_y_q;
      cnt_d = cnt_q + 1'b1;
      sx_d  = sx_q + DIV_W'(s1_x_q);
      sy_d  = sy_q + DIV_W'(s1_y_q);
    end
  end

  // The frame-end pixel is folded into the snapshot while the accumulators restart.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      min_x_q <= '1;  max_x_q <= '0;  min_y_q <= '1;  max_y_q <= '0;
      cnt_q   <= '0;  sx_q    <= '0;  sy_q    <= '0;
      snap_min_x_q <= '0;  snap_max_x_q <= '0;
      snap_min_y_q <= '0;  snap_max_y_q <= '0;
      snap_cnt_q   <= '0;  snap_sx_q    <= '0;  snap_sy_q <= '0;
    end else begin
      if (frame_end || iFRAME_START) begin
        min_x_q <= '1;  max_x_q <= '0;  min_y_q <= '1;  max_y_q <= '0;
        cnt_q   <= '0;  sx_q    <= '0;  sy_q    <= '0;
      end else begin
        min_x_q <= min_x_d;  max_x_q <= max_x_d;
        min_y_q <= min_y_d;  max_y_q <= max_y_d;
        cnt_q   <= cnt_d;    sx_q    <= sx_d;     sy_q <= sy_d;
      end
      if (frame_end) begin
        snap_min_x_q <= min_x_d;  snap_max_x_q <= max_x_d;
        snap_min_y_q <= min_y_d;  snap_max_y_q <= max_y_d;
        snap_cnt_q   <= cnt_d;    snap_sx_q    <= sx_d;     snap_sy_q <= sy_d;
      end
    end
  end

  state_t           state_q;
  logic             snap_new_q, res_val_q, found_q, snap_found, ge, div_last;
  logic [CW-1:0]    rem_q, rem_nx, count_q;
  logic [CW:0]      trial;
  logic [DIV_W-1:0] quo_q, quo_nx;
  logic [NW-1:0]    dcnt_q;
  logic [9:0]       qx_q, qy_q, xmin_q, xmax_q, ymin_q, ymax_q, xcen_q, ycen_q;

  // Restoring division: quo_q starts as the dividend and collects quotient bits from the LSB.
  assign trial      = {rem_q, quo_q[DIV_W-1]};
  assign ge         = trial >= {1'b0, snap_cnt_q};
  assign rem_nx     = ge ? CW'(trial - {1'b0, snap_cnt_q}) : trial[CW-1:0];
  assign quo_nx     = {quo_q[DIV_W-2:0], ge};
  assign div_last   = (dcnt_q == NW'(DIV_W - 1));
  assign snap_found = (snap_cnt_q >= CW'(MIN_COUNT));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      snap_new_q <= 1'b0;
      res_val_q  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dcnt_q     <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      found_q    <= 1'b0;
      count_q    <= '0;
      xmin_q     <= '0;  xmax_q <= '0;  ymin_q <= '0;  ymax_q <= '0;
      xcen_q     <= '0;  ycen_q <= '0;
    end else begin
      res_val_q  <= 1'b0;
      snap_new_q <= frame_end;
      // A fresh snapshot always restarts the decision, aborting any stale division or publish.
      if (snap_new_q) begin
        rem_q   <= '0;
        quo_q   <= snap_sx_q;
        dcnt_q  <= '0;
        state_q <= snap_found ? DIV_X : PUBLISH;
      end else begin
        case (state_q)
          DIV_X, DIV_Y: begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            dcnt_q <= dcnt_q + 1'b1;
            if (div_last) begin
              rem_q  <= '0;
              dcnt_q <= '0;
              if (state_q == DIV_X) begin
                qx_q    <= quo_nx[9:0];
                quo_q   <= snap_sy_q;
                state_q <= DIV_Y;
              end else begin
                qy_q    <= quo_nx[9:0];
                state_q <= PUBLISH;
              end
            end
          end
          PUBLISH: begin
            res_val_q <= 1'b1;
            found_q   <= snap_found;
            count_q   <= snap_cnt_q;
            xmin_q    <= snap_found ? snap_min_x_q : 10'd0;
            xmax_q    <= snap_found ? snap_max_x_q : 10'd0;
            ymin_q    <= snap_found ? snap_min_y_q : 10'd0;
            ymax_q    <= snap_found ? snap_max_y_q : 10'd0;
            xcen_q    <= snap_found ? qx_q : 10'd0;
            ycen_q    <= snap_found ? qy_q : 10'd0;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oR          = pix_r_q;
  assign oG          = pix_g_q;
  assign oB          = pix_b_q;
  assign oDVAL       = s1_dval_q;
  assign oX_MIN      = xmin_q;
  assign oX_MAX      = xmax_q;
  assign oY_MIN      = ymin_q;
  assign oY_MAX      = ymax_q;
  assign oX_CEN      = xcen_q;
  assign oY_CEN      = ycen_q;
  assign oCOUNT      = count_q;
  assign oFOUND      = found_q;
  assign oRESULT_VAL = res_val_q;

endmodule
